// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller for a 5-stage pipeline: tracks in-flight destinations,
// raises load-use (or interlock-only) stalls and registers per-operand forward selects.
module hazard_forward_unit #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        freeze,
  input  logic                        flush,
  input  logic                        id_valid,
  input  logic                        id_reg_write,
  input  logic                        id_is_load,
  input  logic [ADDR_W-1:0]           id_dst_addr,
  input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_used,
  output logic                        stall,
  output logic [2*NUM_SRC-1:0]        fwd_sel,
  output logic                        ex_valid,
  output logic                        mem_valid,
  output logic                        wb_valid,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam logic FWD_ON = (FWD_EN != 0);

  logic              ex_valid_q, ex_valid_d;
  logic [ADDR_W-1:0] ex_dst_q, ex_dst_d;
  logic              ex_load_q, ex_load_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_dst_q, mem_dst_d;
  logic              wb_valid_q, wb_valid_d;
  logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0]   match_ex;
  logic [NUM_SRC-1:0]   match_mem;
  logic [2*NUM_SRC-1:0] fwd_new;
  logic                 hazard;
  logic                 issue;

  // Per-operand comparisons against the EX and MEM slots; WB is covered by regfile write-through.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [ADDR_W-1:0] src;
    logic              src_live;
    assign src      = id_src_addr[gi*ADDR_W +: ADDR_W];
    assign src_live = id_src_used[gi] & (src != '0);
    assign match_ex[gi]  = src_live & ex_valid_q  & (ex_dst_q  == src);
    assign match_mem[gi] = src_live & mem_valid_q & (mem_dst_q == src);
    assign fwd_new[2*gi +: 2] =
        (FWD_ON & match_ex[gi] & ~ex_load_q) ? 2'b10 :
        (FWD_ON & match_mem[gi])             ? 2'b01 : 2'b00;
  end

  // With forwarding only a load in EX blocks; without it any producer in EX or MEM blocks.
  always_comb begin
    hazard = (|(match_ex & {NUM_SRC{ex_load_q | ~FWD_ON}}))
           | ((|match_mem) & ~FWD_ON);
  end

  assign stall = id_valid & ~flush & ~freeze & hazard;
  assign issue = id_valid & ~flush & ~hazard;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_dst_d    = ex_dst_q;
    ex_load_d   = ex_load_q;
    mem_valid_d = mem_valid_q;
    mem_dst_d   = mem_dst_q;
    wb_valid_d  = wb_valid_q;
    fwd_sel_d   = fwd_sel_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      wb_valid_d  = mem_valid_q;
      mem_valid_d = ex_valid_q;
      mem_dst_d   = ex_dst_q;
      ex_valid_d  = issue & id_reg_write & (id_dst_addr != '0);
      ex_dst_d    = id_dst_addr;
      ex_load_d   = id_is_load;
      fwd_sel_d   = issue ? fwd_new : '0;
      if (stall && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_dst_q    <= '0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_dst_q   <= '0;
      wb_valid_q  <= 1'b0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_dst_q    <= ex_dst_d;
      ex_load_q   <= ex_load_d;
      mem_valid_q <= mem_valid_d;
      mem_dst_q   <= mem_dst_d;
      wb_valid_q  <= wb_valid_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_sel   = fwd_sel_q;
  assign ex_valid  = ex_valid_q;
  assign mem_valid = mem_valid_q;
  assign wb_valid  = wb_valid_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: one interlock-only instance and one forwarding instance
// share the ID stimulus; a per-instance slot model feeds a scoreboard of registered outputs.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       freeze = 1'b0;
  logic       flush = 1'b0;
  logic       id_valid = 1'b0;
  logic       id_reg_write = 1'b0;
  logic       id_is_load = 1'b0;
  logic [4:0] id_dst_addr = '0;
  logic [9:0] id_src_addr = '0;
  logic [1:0] id_src_used = '0;

  logic        stall0, stall1;
  logic [3:0]  fwd0, fwd1;
  logic        ev0, mv0, wv0, ev1, mv1, wv1;
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  hazard_forward_unit #(.ADDR_W(5), .NUM_SRC(2), .FWD_EN(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_dst_addr(id_dst_addr),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used), .stall(stall0), .fwd_sel(fwd0),
    .ex_valid(ev0), .mem_valid(mv0), .wb_valid(wv0), .stall_cnt(cnt0));

  hazard_forward_unit #(.ADDR_W(5), .NUM_SRC(2), .FWD_EN(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_dst_addr(id_dst_addr),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used), .stall(stall1), .fwd_sel(fwd1),
    .ex_valid(ev1), .mem_valid(mv1), .wb_valid(wv1), .stall_cnt(cnt1));

  typedef struct {
    logic [3:0]  fs;
    logic        ev, mv, wv;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  // Index 0 models the interlock-only instance, index 1 the forwarding one.
  bit          m_ev[2], m_mv[2], m_wv[2], m_el[2];
  logic [4:0]  m_ed[2], m_md[2];
  logic [3:0]  m_fs[2];
  int unsigned m_cnt[2];
  int unsigned cnt_max[2] = '{15, 65535};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      m_ev[m] = 0; m_mv[m] = 0; m_wv[m] = 0; m_el[m] = 0;
      m_ed[m] = '0; m_md[m] = '0; m_fs[m] = '0; m_cnt[m] = 0;
    end
  endtask

  task automatic set_id(input bit v, input bit rw, input bit ld, input int dst,
                        input int s0, input int s1, input logic [1:0] used);
    id_valid = v; id_reg_write = rw; id_is_load = ld;
    id_dst_addr = dst[4:0];
    id_src_addr = {s1[4:0], s0[4:0]};
    id_src_used = used;
  endtask

  // Called right after inputs change on the falling edge; checks stall, clocks, checks outputs.
  task automatic step(input string tag);
    logic [4:0] s[2];
    logic [3:0] nfs;
    bit mex, mmem, haz, stl, bub;
    exp_t e;
    logic [3:0]  a_fs;
    logic        a_ev, a_mv, a_wv;
    logic [15:0] a_cnt;
    s[0] = id_src_addr[4:0];
    s[1] = id_src_addr[9:5];
    #1;
    $display("step %s: v=%b rw=%b ld=%b dst=%0d src=%0d/%0d used=%b frz=%b fl=%b stall0=%b stall1=%b",
             tag, id_valid, id_reg_write, id_is_load, id_dst_addr, s[0], s[1], id_src_used,
             freeze, flush, stall0, stall1);
    for (int m = 0; m < 2; m++) begin
      haz = 0;
      nfs = '0;
      for (int i = 0; i < 2; i++) begin
        mex  = id_src_used[i] && m_ev[m] && (m_ed[m] == s[i]) && (s[i] != 0);
        mmem = id_src_used[i] && m_mv[m] && (m_md[m] == s[i]) && (s[i] != 0);
        if (m == 1) begin
          if (mex && m_el[m]) haz = 1;
          if (mex && !m_el[m]) nfs[2*i +: 2] = 2'b10;
          else if (mmem)       nfs[2*i +: 2] = 2'b01;
        end else if (mex || mmem) begin
          haz = 1;
        end
      end
      stl = id_valid && !flush && !freeze && haz;
      check_eq({tag, (m == 1) ? "/stall1" : "/stall0"}, {31'b0, (m == 1) ? stall1 : stall0}, {31'b0, stl});
      if (!freeze) begin
        bub = stl || flush || !id_valid;
        m_wv[m] = m_mv[m];
        m_mv[m] = m_ev[m];
        m_md[m] = m_ed[m];
        m_ev[m] = !bub && id_reg_write && (id_dst_addr != 0);
        m_ed[m] = id_dst_addr;
        m_el[m] = id_is_load;
        m_fs[m] = bub ? 4'b0 : nfs;
        if (stl && m_cnt[m] != cnt_max[m]) m_cnt[m]++;
      end
      e.fs = m_fs[m]; e.ev = m_ev[m]; e.mv = m_mv[m]; e.wv = m_wv[m]; e.cnt = m_cnt[m][15:0];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (sb_q.size() == 0) begin
        check_eq({tag, "/sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        if (m == 0) begin a_fs = fwd0; a_ev = ev0; a_mv = mv0; a_wv = wv0; a_cnt = {12'b0, cnt0}; end
        else        begin a_fs = fwd1; a_ev = ev1; a_mv = mv1; a_wv = wv1; a_cnt = cnt1; end
        check_eq($sformatf("%s/fwd%0d", tag, m), {28'b0, a_fs}, {28'b0, e.fs});
        check_eq($sformatf("%s/valid%0d", tag, m), {29'b0, a_ev, a_mv, a_wv}, {29'b0, e.ev, e.mv, e.wv});
        check_eq($sformatf("%s/cnt%0d", tag, m), {16'b0, a_cnt}, {16'b0, e.cnt});
      end
    end
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks that it takes effect without a clock.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_eq({tag, "/rst_valid"}, {26'b0, ev0, mv0, wv0, ev1, mv1, wv1}, 32'd0);
    check_eq({tag, "/rst_fwd"}, {24'b0, fwd0, fwd1}, 32'd0);
    check_eq({tag, "/rst_cnt"}, {12'b0, cnt0, cnt1}, 32'd0);
    check_eq({tag, "/rst_stall"}, {30'b0, stall0, stall1}, 32'd0);
    $display("reset %s applied", tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    @(negedge clk);
    do_reset("init");

    // Reset while slots are occupied
    set_id(1, 1, 0, 1, 0, 0, 2'b00); step("t1a");
    set_id(1, 1, 1, 2, 0, 0, 2'b00); step("t1b");
    do_reset("t1");

    // Forward from EX/MEM on operand 0
    set_id(1, 1, 0, 3, 0, 0, 2'b00); step("t2a");
    set_id(1, 1, 0, 6, 3, 0, 2'b01); step("t2b");
    check_eq("t2/fwd_op0", {30'b0, fwd1[1:0]}, 32'b10);
    do_reset("t2");

    // Load-use on operand 1: one stall, then MEM/WB forward
    set_id(1, 1, 1, 5, 0, 0, 2'b00); step("t3a");
    set_id(1, 1, 0, 8, 0, 5, 2'b10); step("t3b");
    check_eq("t3/cnt_after_stall", {16'b0, cnt1}, 32'd1);
    check_eq("t3/ex_bubble", {31'b0, ev1}, 32'd0);
    step("t3c");
    check_eq("t3/fwd_op1", {30'b0, fwd1[3:2]}, 32'b01);
    do_reset("t3");

    // Newest producer wins; r0 never forwards
    set_id(1, 1, 0, 4, 0, 0, 2'b00); step("t4a");
    set_id(1, 1, 0, 4, 0, 0, 2'b00); step("t4b");
    set_id(1, 0, 0, 0, 4, 4, 2'b11); step("t4c");
    check_eq("t4/newest", {28'b0, fwd1}, 32'b1010);
    set_id(1, 1, 0, 0, 0, 0, 2'b00); step("t4d");
    set_id(1, 0, 0, 0, 0, 0, 2'b11); step("t4e");
    check_eq("t4/r0", {28'b0, fwd1}, 32'd0);
    do_reset("t4");

    // Interlock-only instance stalls two cycles on an ALU producer
    set_id(1, 1, 0, 7, 0, 0, 2'b00); step("t5a");
    set_id(1, 1, 0, 9, 7, 0, 2'b01); step("t5b");
    step("t5c");
    check_eq("t5/cnt0", {28'b0, cnt0}, 32'd2);
    step("t5d");
    check_eq("t5/fwd0", {28'b0, fwd0}, 32'd0);
    do_reset("t5");

    // Freeze over a load-use hazard, then flush over a hazard
    set_id(1, 1, 1, 9, 0, 0, 2'b00); step("t6a");
    set_id(1, 1, 0, 11, 9, 0, 2'b01);
    freeze = 1'b1;
    step("t6f1"); step("t6f2"); step("t6f3");
    freeze = 1'b0;
    step("t6b"); step("t6c");
    set_id(1, 1, 1, 10, 0, 0, 2'b00); step("t6d");
    set_id(1, 1, 0, 12, 10, 0, 2'b01);
    flush = 1'b1;
    step("t6e");
    flush = 1'b0;
    do_reset("t6");

    // Random traffic on a small register window, including counter saturation
    for (int k = 0; k < 300; k++) begin
      set_id($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)));
      freeze = ($urandom_range(0, 9) == 0);
      flush  = ($urandom_range(0, 11) == 0);
      step($sformatf("r%0d", k));
      if (k == 150) do_reset("rmid");
    end
    freeze = 1'b0;
    flush  = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
